// File: rtl/fight_scheduler_pkg.sv
// rtl/fight_scheduler_pkg.sv - shared types, default constants and health arithmetic for the fight scheduler
package fight_pkg;

    typedef logic [7:0] health_t;

    typedef enum logic [1:0] {
        IDLE,
        WINDUP,
        STRIKE,
        COOLDOWN
    } fstate_t;

    localparam int HEALTH_INIT_D     = 100;
    localparam int DAMAGE_D          = 10;
    localparam int BLOCK_DAMAGE_D    = 2;
    localparam int WINDUP_FRAMES_D   = 3;
    localparam int COOLDOWN_FRAMES_D = 8;

    function automatic health_t sat_sub(input health_t h, input health_t d);
        return (d >= h) ? '0 : health_t'(h - d);
    endfunction

endpackage

// File: rtl/fight_scheduler_if.sv
// rtl/fight_scheduler_if.sv - player controls, frame tick and animation/score outputs of the fight scheduler
interface fight_scheduler_if;
    import fight_pkg::*;

    logic    frame_tick;
    logic    p1_atk_req;
    logic    p2_atk_req;
    logic    p1_block;
    logic    p2_block;
    logic    in_range;
    logic    p1_punch_go;
    logic    p2_punch_go;
    logic    p1_hit;
    logic    p2_hit;
    health_t p1_health;
    health_t p2_health;
    logic    ko;
    logic    winner;

    modport master (
        output frame_tick, p1_atk_req, p2_atk_req, p1_block, p2_block, in_range,
        input  p1_punch_go, p2_punch_go, p1_hit, p2_hit, p1_health, p2_health, ko, winner
    );

    modport slave (
        input  frame_tick, p1_atk_req, p2_atk_req, p1_block, p2_block, in_range,
        output p1_punch_go, p2_punch_go, p1_hit, p2_hit, p1_health, p2_health, ko, winner
    );

endinterface

// File: rtl/fight_scheduler_fighter_seq.sv
// rtl/fight_scheduler_fighter_seq.sv - per-player attack sequencer: windup, one-clk strike, cooldown, stun override
module fighter_seq
    import fight_pkg::*;
#(
    parameter int WINDUP_FRAMES   = WINDUP_FRAMES_D,
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_D
) (
    input  logic    clk,
    input  logic    Reset,
    input  logic    frame_tick,
    input  logic    atk_req,
    input  logic    block,
    input  logic    freeze,
    input  logic    stun,
    output fstate_t state,
    output logic    punch_go
);

    localparam logic [7:0] WF = 8'(WINDUP_FRAMES);
    localparam logic [7:0] CF = 8'(COOLDOWN_FRAMES);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            punch_go <= 1'b0;
        end else begin
            punch_go <= 1'b0;
            if (freeze) begin
                state <= state;
            end else if (stun) begin
                // being hit cancels any pending attack and restarts recovery
                state <= COOLDOWN;
                cnt   <= CF;
            end else begin
                case (state)
                    IDLE: if (atk_req && !block) begin
                        state    <= WINDUP;
                        cnt      <= WF;
                        punch_go <= 1'b1;
                    end
                    WINDUP: if (frame_tick) begin
                        if (cnt == 8'd1) state <= STRIKE;
                        cnt <= cnt - 8'd1;
                    end
                    STRIKE: begin
                        state <= COOLDOWN;
                        cnt   <= CF;
                    end
                    COOLDOWN: if (frame_tick) begin
                        if (cnt == 8'd1) state <= IDLE;
                        cnt <= cnt - 8'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/fight_scheduler.sv
// rtl/fight_scheduler.sv - two-fighter strike resolution, health and KO; CHIP_DAMAGE_EN enables blocked-hit damage
module fight_scheduler
    import fight_pkg::*;
#(
    parameter int HEALTH_INIT     = HEALTH_INIT_D,
    parameter int DAMAGE          = DAMAGE_D,
    parameter int WINDUP_FRAMES   = WINDUP_FRAMES_D,
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_D
`ifdef CHIP_DAMAGE_EN
    ,
    parameter int BLOCK_DAMAGE    = BLOCK_DAMAGE_D
`endif
) (
    input logic              clk,
    input logic              Reset,
    fight_scheduler_if.slave bus
);

    localparam health_t DMG = health_t'(DAMAGE);
`ifdef CHIP_DAMAGE_EN
    localparam health_t CHIP = health_t'(BLOCK_DAMAGE);
`else
    localparam health_t CHIP = '0;
`endif

    fstate_t st1, st2;
    logic    stun1, stun2;
    logic    guard1, guard2, lands1, lands2;
    health_t dmg1, dmg2, h1_next, h2_next;

    fighter_seq #(.WINDUP_FRAMES(WINDUP_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_p1 (
        .clk(clk), .Reset(Reset), .frame_tick(bus.frame_tick), .atk_req(bus.p1_atk_req),
        .block(bus.p1_block), .freeze(bus.ko), .stun(stun1), .state(st1), .punch_go(bus.p1_punch_go)
    );

    fighter_seq #(.WINDUP_FRAMES(WINDUP_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_p2 (
        .clk(clk), .Reset(Reset), .frame_tick(bus.frame_tick), .atk_req(bus.p2_atk_req),
        .block(bus.p2_block), .freeze(bus.ko), .stun(stun2), .state(st2), .punch_go(bus.p2_punch_go)
    );

    // a guard only counts for a player standing idle; a simultaneous strike is a clash
    assign guard1 = bus.p1_block && (st1 == IDLE);
    assign guard2 = bus.p2_block && (st2 == IDLE);
    assign lands1 = (st1 == STRIKE) && (st2 != STRIKE) && bus.in_range && !bus.ko;
    assign lands2 = (st2 == STRIKE) && (st1 != STRIKE) && bus.in_range && !bus.ko;
    assign stun2  = lands1 && !guard2;
    assign stun1  = lands2 && !guard1;

    always_comb begin
        dmg1 = '0;
        dmg2 = '0;
        if (lands1) dmg2 = guard2 ? CHIP : DMG;
        if (lands2) dmg1 = guard1 ? CHIP : DMG;
        h1_next = sat_sub(bus.p1_health, dmg1);
        h2_next = sat_sub(bus.p2_health, dmg2);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            bus.p1_health <= health_t'(HEALTH_INIT);
            bus.p2_health <= health_t'(HEALTH_INIT);
            bus.p1_hit    <= 1'b0;
            bus.p2_hit    <= 1'b0;
            bus.ko        <= 1'b0;
            bus.winner    <= 1'b0;
        end else begin
            bus.p1_hit <= stun1;
            bus.p2_hit <= stun2;
            if (lands1) begin
                bus.p2_health <= h2_next;
                if (h2_next == '0) begin
                    bus.ko     <= 1'b1;
                    bus.winner <= 1'b0;
                end
            end
            if (lands2) begin
                bus.p1_health <= h1_next;
                if (h1_next == '0) begin
                    bus.ko     <= 1'b1;
                    bus.winner <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fight_scheduler.sv
// tb/tb_fight_scheduler.sv - directed and randomized checks of fight_scheduler against a frame-level fight model
module tb_fight_scheduler;

    localparam int HP    = 100;
    localparam int DMG   = 10;
    localparam int WF    = 3;
    localparam int CF    = 8;
`ifdef CHIP_DAMAGE_EN
    localparam int CHIP  = 2;
`else
    localparam int CHIP  = 0;
`endif

    logic clk = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    fight_scheduler_if bus ();
    fight_scheduler dut (.clk(clk), .Reset(Reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    // model: windup ticks left, cooldown ticks left, striking flag per player
    int wind[2], cool[2], health[2];
    bit striking[2], m_go[2], m_hit[2], m_ko, m_win;
    int n_go[2], n_hit[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            wind[p] = 0; cool[p] = 0; striking[p] = 0;
            health[p] = HP; m_go[p] = 0; m_hit[p] = 0;
        end
        m_ko = 0; m_win = 0;
    endtask

    task automatic model_step(input bit tick, input bit r1, input bit r2,
                              input bit b1, input bit b2, input bit rng);
        bit req[2], blk[2], idle[2], stun[2], frozen;
        int att, d, dmg;
        req = '{r1, r2}; blk = '{b1, b2};
        frozen = m_ko;
        for (int p = 0; p < 2; p++) begin
            idle[p] = (wind[p] == 0) && !striking[p] && (cool[p] == 0);
            stun[p] = 0; m_go[p] = 0; m_hit[p] = 0;
        end
        if (!frozen && (striking[0] != striking[1]) && rng) begin
            att = striking[0] ? 0 : 1;
            d   = 1 - att;
            dmg = (blk[d] && idle[d]) ? CHIP : DMG;
            if (!(blk[d] && idle[d])) begin
                stun[d] = 1; m_hit[d] = 1;
            end
            if (dmg > 0) begin
                health[d] = (dmg >= health[d]) ? 0 : health[d] - dmg;
                if (health[d] == 0) begin m_ko = 1; m_win = (att == 1); end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (frozen) continue;
            if (stun[p]) begin
                wind[p] = 0; striking[p] = 0; cool[p] = CF;
            end else if (striking[p]) begin
                striking[p] = 0; cool[p] = CF;
            end else if (wind[p] > 0) begin
                if (tick) begin
                    wind[p]--;
                    if (wind[p] == 0) striking[p] = 1;
                end
            end else if (cool[p] > 0) begin
                if (tick) cool[p]--;
            end else if (req[p] && !blk[p]) begin
                wind[p] = WF; m_go[p] = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_pulses"}, {28'd0, bus.p1_punch_go, bus.p2_punch_go, bus.p1_hit, bus.p2_hit},
            {28'd0, m_go[0], m_go[1], m_hit[0], m_hit[1]});
        chk({tag, "_p1_health"}, 32'(bus.p1_health), 32'(health[0]));
        chk({tag, "_p2_health"}, 32'(bus.p2_health), 32'(health[1]));
        chk({tag, "_ko_winner"}, {30'd0, bus.ko, bus.winner}, {30'd0, m_ko, m_win});
    endtask

    task automatic cycle(input bit tick, input bit r1, input bit r2,
                         input bit b1, input bit b2, input bit rng);
        bus.frame_tick = tick; bus.p1_atk_req = r1; bus.p2_atk_req = r2;
        bus.p1_block = b1; bus.p2_block = b2; bus.in_range = rng;
        @(posedge clk);
        model_step(tick, r1, r2, b1, b2, rng);
        #1;
        compare_all("cyc");
        n_go[0] += int'(bus.p1_punch_go); n_go[1] += int'(bus.p2_punch_go);
        n_hit[0] += int'(bus.p1_hit);     n_hit[1] += int'(bus.p2_hit);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit b1, input bit b2, input bit rng);
        for (int i = 0; i < n; i++) cycle(i % 2 == 0, 1'b0, 1'b0, b1, b2, rng);
    endtask

    task automatic clear_counts();
        n_go = '{0, 0}; n_hit = '{0, 0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        bus.frame_tick = 0; bus.p1_atk_req = 0; bus.p2_atk_req = 0;
        bus.p1_block = 0; bus.p2_block = 0; bus.in_range = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        Reset = 1'b0;
        clear_counts();
    endtask

    initial begin
        // single in-range hit
        do_reset();
        cycle(0, 1, 0, 0, 0, 1);
        chk("s1_punch_go", {31'd0, bus.p1_punch_go}, 32'd1);
        run(40, 0, 0, 1);
        chk("s1_p2_health", 32'(bus.p2_health), 32'd90);
        chk("s1_p2_hit_count", n_hit[1], 1);

        // whiff out of range, then P1 can attack again
        do_reset();
        cycle(0, 1, 0, 0, 0, 0);
        run(30, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("s2_hits", n_hit[0] + n_hit[1], 0);
        chk("s2_health", {16'd0, bus.p1_health, bus.p2_health}, {16'd0, 8'd100, 8'd100});
        chk("s2_rego_count", n_go[0], 2);

        // clash
        do_reset();
        cycle(0, 1, 1, 0, 0, 1);
        run(30, 0, 0, 1);
        chk("s3_hits", n_hit[0] + n_hit[1], 0);
        chk("s3_health", {16'd0, bus.p1_health, bus.p2_health}, {16'd0, 8'd100, 8'd100});

        // blocked hit
        do_reset();
        cycle(0, 1, 0, 0, 1, 1);
        run(30, 0, 1, 1);
        chk("s4_p2_hit_count", n_hit[1], 0);
        chk("s4_p2_health", 32'(bus.p2_health), 32'(HP - CHIP));

        // P2 caught in windup
        do_reset();
        cycle(0, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 1);
        run(40, 0, 0, 1);
        chk("s5_p2_hit_count", n_hit[1], 1);
        chk("s5_p1_hit_count", n_hit[0], 0);
        chk("s5_health", {16'd0, bus.p1_health, bus.p2_health}, {16'd0, 8'd100, 8'd90});

        // ten hits to KO, then frozen
        do_reset();
        for (int k = 0; k < 10; k++) begin
            cycle(0, 1, 0, 0, 0, 1);
            run(30, 0, 0, 1);
        end
        chk("s6_ko", {29'd0, bus.ko, bus.winner, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("s6_p2_health", 32'(bus.p2_health), 32'd0);
        clear_counts();
        for (int k = 0; k < 20; k++) cycle(k % 2 == 0, 1, 1, 0, 0, 1);
        chk("s6_post_ko_go", n_go[0] + n_go[1], 0);

        // async reset mid-windup
        do_reset();
        cycle(0, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_reset");
        do_reset();

        // randomized matches
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 700; i++)
                cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
